bell_tone_sel: RTL and testbench
================================

// Module: bell_tone_sel
// PURPOSE
//  Parametrised doorbell tone generator: one shared prescaler and one programmable divider replace per-tone divider banks.
//  Two buttons step a binary tone index up/down (with wrap); a ring request plays the selected tone for a fixed duration.
//  Sits between the board buttons and the buzzer pin, on the main system clock.
// PARAMETERS
//  PRE_DIV    5000  clk cycles per base tick (>=2); tick = 1-clk pulse, free-running from reset
//  N_TONES    20    number of selectable tones (>=2); tone i half-period = (i+1) ticks
//  DUR_TICKS  1000  ring duration in ticks (>=1)
//  DEB_TICKS  8     debounce stability window in ticks (used only with BELL_TONE_SEL_DEBOUNCE_EN)
// PORTS
//  clk       in   1                  system clock, all logic on rising edge
//  _rst      in   1                  asynchronous active-low reset
//  btn_up    in   1                  raw button, step tone index up
//  btn_dn    in   1                  raw button, step tone index down
//  ring      in   1                  raw ring request, acts on rising edge
//  out       out  1                  square-wave buzzer drive
//  busy      out  1                  high while a ring is playing
//  tone_idx  out  $clog2(N_TONES)    currently selected tone
// BEHAVIOUR
//  Reset (_rst=0, async): out=0, busy=0, tone_idx=0, all counters/sync flops 0, FSM=IDLE; held while _rst=0.
//  Inputs: each of btn_up/btn_dn/ring passes a 2-FF synchroniser, then a registered rising-edge detector;
//   the resulting 1-clk pulse acts on the 3rd rising clk edge after the raw input is first sampled high.
//  Prescaler: cnt 0..PRE_DIV-1, tick=1 when cnt==PRE_DIV-1, cnt then wraps to 0.
//  Tone index: up pulse -> +1, N_TONES-1 wraps to 0; dn pulse -> -1, 0 wraps to N_TONES-1;
//   up and dn pulses in the same cycle -> no change. Index updates in any FSM state.
//  FSM IDLE: busy=0, out=0. ring pulse -> RING: tone_lat<=tone_idx, dur<=DUR_TICKS, half<=0, out<=0.
//  FSM RING: busy=1. On each tick: if half==tone_lat then out toggles, half<=0, else half<=half+1;
//   dur<=dur-1; tick with dur==1 -> IDLE, out<=0 (same edge). Ring lasts exactly DUR_TICKS ticks.
//  Tone frequency = f_clk / (PRE_DIV * 2 * (tone_lat+1)); first toggle at tone_lat+1 ticks after entry.
//  Index change during RING updates tone_idx only; playing tone (tone_lat) is fixed until next ring.
//  ring pulse during RING: retrigger -> dur<=DUR_TICKS, tone_lat<=tone_idx, half<=0, out kept (phase not reset).
//  ring pulse coinciding with final tick: retrigger wins, stays in RING.
//  Entry to RING is not tick-aligned: first tick may arrive 1..PRE_DIV clk after entry.
// CONFIGURATION
//  BELL_TONE_SEL_DEBOUNCE_EN defined: after the synchroniser each input feeds a debouncer; its filtered level
//   changes only after the synced level has differed from it on DEB_TICKS consecutive ticks; edge detect on
//   filtered level. Press latency becomes up to (DEB_TICKS+1)*PRE_DIV+3 clk; shorter glitches ignored.
//  Not defined: no debouncer, edge detect directly on synchroniser output; DEB_TICKS ignored.
// TESTING (PRE_DIV=4, N_TONES=4, DUR_TICKS=16 unless stated)
//  1 Assert _rst=0 for 5 clk, release -> out=0, busy=0, tone_idx=0; tick every 4 clk from release.
//  2 Three btn_up presses -> tone_idx=3; one more -> 0; btn_dn at 0 -> 3; up+dn same clk -> unchanged.
//  3 tone_idx=0, ring pulse -> busy=1 for 16 ticks (64 clk +/- tick phase), out period 8 clk, 8 periods, then out=0,busy=0.
//  4 tone_idx=1, ring, btn_up at tick 5 -> tone_idx=2 while out period stays 16 clk until ring ends.
//  5 ring retrigger at tick 10 -> busy stays high 26 ticks total; _rst=0 mid-ring -> out=0, busy=0, tone_idx=0 same time step.
//  6 With BELL_TONE_SEL_DEBOUNCE_EN, DEB_TICKS=8: 3-tick btn_up glitch -> no change; 12-tick press -> tone_idx +1 once.

Source files
------------

// File: rtl/bell_tone_sel.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bell_tone_sel
//   Doorbell tone generator. One shared prescaler produces a 1-clk "tick" every
//   PRE_DIV clocks; a single programmable half-period counter derives the
//   selected tone from it. Two buttons step the tone index (with wrap) and a
//   ring request plays the latched tone for DUR_TICKS ticks.
//
// Build option:
//   BELL_TONE_SEL_DEBOUNCE_EN - when defined, each synchronised input passes a
//   tick-based debouncer (DEB_TICKS stable ticks) before edge detection.
//
// Ports:
//   clk       in   system clock, rising edge
//   _rst      in   asynchronous active-low reset
//   btn_up    in   raw button, step tone index up
//   btn_dn    in   raw button, step tone index down
//   ring      in   raw ring request (rising edge)
//   out       out  square-wave buzzer drive
//   busy      out  high while a ring is playing
//   tone_idx  out  currently selected tone
// -----------------------------------------------------------------------------
module bell_tone_sel #(
  parameter int PRE_DIV   = 5000,
  parameter int N_TONES   = 20,
  parameter int DUR_TICKS = 1000,
  parameter int DEB_TICKS = 8
) (
  input  logic                       clk,
  input  logic                       _rst,
  input  logic                       btn_up,
  input  logic                       btn_dn,
  input  logic                       ring,
  output logic                       out,
  output logic                       busy,
  output logic [$clog2(N_TONES)-1:0] tone_idx
);

  localparam int TW = $clog2(N_TONES);
  localparam int PW = $clog2(PRE_DIV);
  localparam int DW = $clog2(DUR_TICKS + 1);

  if (PRE_DIV < 2 || N_TONES < 2 || DUR_TICKS < 1 || DEB_TICKS < 1) begin : g_param_check
    $error("bell_tone_sel: illegal parameter value");
  end

  typedef enum logic {S_IDLE, S_RING} state_e;

  // ---------------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_cnt_q;
  logic          tick;

  assign tick = (pre_cnt_q == PW'(PRE_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, regardless of block ordering.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst)     pre_cnt_q <= '0;
    else if (tick) pre_cnt_q <= '0;
    else           pre_cnt_q <= pre_cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Input conditioning: bit 0 = up, bit 1 = down, bit 2 = ring
  // ---------------------------------------------------------------------------
  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level;
  logic [2:0] prev_q;
  logic [2:0] pulse;

  assign raw = {ring, btn_dn, btn_up};

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef BELL_TONE_SEL_DEBOUNCE_EN
  localparam int BW = $clog2(DEB_TICKS + 1);

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic          filt_q;
    logic [BW-1:0] cnt_q;

    // The filtered level flips only after the synced level has disagreed with
    // it on DEB_TICKS consecutive ticks; any agreeing tick restarts the count.
    always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else if (tick) begin
        if (sync2_q[g] != filt_q) begin
          if (cnt_q == BW'(DEB_TICKS - 1)) begin
            filt_q <= sync2_q[g];
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign level[g] = filt_q;
  end
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) prev_q <= '0;
    else       prev_q <= level;
  end

  assign pulse = level & ~prev_q;

  // ---------------------------------------------------------------------------
  // Tone index (updates in any FSM state)
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tone_q, tone_d;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tone_d = tone_q;
    if (pulse[0] && !pulse[1]) begin
      tone_d = (tone_q == TW'(N_TONES - 1)) ? '0 : tone_q + 1'b1;
    end else if (pulse[1] && !pulse[0]) begin
      tone_d = (tone_q == '0) ? TW'(N_TONES - 1) : tone_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) tone_q <= '0;
    else       tone_q <= tone_d;
  end

  // ---------------------------------------------------------------------------
  // Ring FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [TW-1:0] tone_lat_q, tone_lat_d;
  logic [TW-1:0] half_q, half_d;
  logic [DW-1:0] dur_q, dur_d;
  logic          out_q, out_d;

  always_comb begin
    state_d    = state_q;
    tone_lat_d = tone_lat_q;
    half_d     = half_q;
    dur_d      = dur_q;
    out_d      = out_q;
    unique case (state_q)
      S_IDLE: begin
        out_d = 1'b0;
        if (pulse[2]) begin
          state_d    = S_RING;
          tone_lat_d = tone_q;
          dur_d      = DW'(DUR_TICKS);
          half_d     = '0;
        end
      end
      S_RING: begin
        // A retrigger takes priority over a coincident tick (including the
        // final one) and keeps the output phase.
        if (pulse[2]) begin
          tone_lat_d = tone_q;
          dur_d      = DW'(DUR_TICKS);
          half_d     = '0;
        end else if (tick) begin
          if (half_q == tone_lat_q) begin
            out_d  = ~out_q;
            half_d = '0;
          end else begin
            half_d = half_q + 1'b1;
          end
          dur_d = dur_q - 1'b1;
          if (dur_q == DW'(1)) begin
            state_d = S_IDLE;
            out_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q    <= S_IDLE;
      tone_lat_q <= '0;
      half_q     <= '0;
      dur_q      <= '0;
      out_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tone_lat_q <= tone_lat_d;
      half_q     <= half_d;
      dur_q      <= dur_d;
      out_q      <= out_d;
    end
  end

  assign out      = out_q;
  assign busy     = (state_q == S_RING);
  assign tone_idx = tone_q;

endmodule

// File: tb/tb_bell_tone_sel.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bell_tone_sel
//   Self-checking bench for bell_tone_sel with PRE_DIV=4, N_TONES=4,
//   DUR_TICKS=16. The reference model works from edge counts: a tick acts on
//   every edge whose post-edge count is a multiple of PRE_DIV, a pulse acts
//   three edges after the raw input is driven, and out/busy follow from the
//   number of ticks elapsed since ring entry.
// -----------------------------------------------------------------------------
module tb_bell_tone_sel;

  localparam int P = 4;
  localparam int N = 4;
  localparam int D = 16;
  localparam int DEB = 8;

`ifdef BELL_TONE_SEL_DEBOUNCE_EN
  localparam int HOLD = 48;
  localparam int GAP  = 60;
`else
  localparam int HOLD = 2;
  localparam int GAP  = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_l;
  logic       btn_up, btn_dn, ring;
  logic       out, busy;
  logic [1:0] tone_idx;

  int checks = 0;
  int errors = 0;
  int edge_cnt;
  int exp_idx = 0;

  always #5 clk = ~clk;

  bell_tone_sel #(
    .PRE_DIV  (P),
    .N_TONES  (N),
    .DUR_TICKS(D),
    .DEB_TICKS(DEB)
  ) dut (
    .clk     (clk),
    ._rst    (rst_l),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .ring    (ring),
    .out     (out),
    .busy    (busy),
    .tone_idx(tone_idx)
  );

  // Number of rising edges since reset release.
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up = up;
    btn_dn = dn;
    repeat (HOLD) step();
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (GAP) step();
    if (up && !dn) exp_idx = (exp_idx + 1) % N;
    if (dn && !up) exp_idx = (exp_idx + N - 1) % N;
  endtask

  task automatic check_idx(input string name);
    checks++;
    if (tone_idx !== 2'(exp_idx)) begin
      errors++;
      $display("FAIL %s: tone_idx=%0d expected %0d", name, tone_idx, exp_idx);
    end
  endtask

  task automatic set_index(input int target);
    while (exp_idx != target) press(1'b1, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_l  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    ring   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_up = 1'($urandom);
      ring   = 1'($urandom);
      step();
      checks++;
      if (out !== 1'b0 || busy !== 1'b0 || tone_idx !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: out=%b busy=%b idx=%0d expected 0/0/0", out, busy, tone_idx);
      end
    end
    btn_up = 1'b0;
    ring   = 1'b0;
    rst_l  = 1'b1;
    exp_idx = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (dut.tick !== ((edge_cnt % P) == P - 1) || out !== 1'b0 || busy !== 1'b0 ||
          tone_idx !== 2'd0) begin
        errors++;
        $display("FAIL reset_release: edge %0d tick=%b out=%b busy=%b idx=%0d expected tick=%b 0/0/0",
                 edge_cnt, dut.tick, out, busy, tone_idx, ((edge_cnt % P) == P - 1));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_tone_index();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    check_idx("up_x3");
    press(1'b1, 1'b0);
    check_idx("up_wrap");
    press(1'b0, 1'b1);
    check_idx("dn_wrap");
    press(1'b1, 1'b1);
    check_idx("up_dn_same");
    for (int i = 0; i < 10; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      press(sel != 1, sel != 0);
      check_idx("random_step");
    end
  endtask

  // ---------------------------------------------------------------------------
  // One ring. idx_chg_tick / retrig_tick < 0 disable those events; otherwise
  // they are driven once the model has seen that many ticks since entry.
  task automatic test_ring(input string name, input int lat, input int idx_chg_tick,
                           input int retrig_tick);
    int entry, base, lat_cur, lat_next, o, r_edge, c, n, post, up_cnt, ring_cnt;
    bit exp_busy, exp_out, retrig_done, chg_done;
    set_index(lat);
    repeat ($urandom_range(0, P - 1)) step();
    ring     = 1'b1;
    ring_cnt = 2;
    up_cnt   = 0;
    entry    = edge_cnt + 3;
    base     = entry;
    lat_cur  = lat;
    lat_next = lat;
    o        = 0;
    r_edge   = -1;
    post     = 0;
    retrig_done = 0;
    chg_done    = 0;
    for (int it = 0; it < 3000; it++) begin
      step();
      c = edge_cnt;
      if (c == r_edge) begin
        o       = (((r_edge - 1) / P - entry / P) / (lat + 1)) % 2;
        base    = r_edge;
        lat_cur = lat_next;
      end
      if (c < entry) begin
        n = -1;
        exp_busy = 0;
        exp_out  = 0;
      end else begin
        n = c / P - base / P;
        exp_busy = (n < D);
        exp_out  = exp_busy ? 1'(o ^ ((n / (lat_cur + 1)) % 2)) : 1'b0;
      end
      checks++;
      if (busy !== exp_busy || out !== exp_out) begin
        errors++;
        $display("FAIL %s: edge %0d busy=%b out=%b expected busy=%b out=%b",
                 name, c, busy, out, exp_busy, exp_out);
      end
      if (ring_cnt > 0) begin
        ring_cnt--;
        if (ring_cnt == 0) ring = 1'b0;
      end
      if (up_cnt > 0) begin
        up_cnt--;
        if (up_cnt == 0) btn_up = 1'b0;
      end
      if (!retrig_done && retrig_tick >= 0 && base == entry && n == retrig_tick) begin
        ring     = 1'b1;
        ring_cnt = 2;
        r_edge   = c + 3;
        lat_next = exp_idx;
        retrig_done = 1;
      end
      if (!chg_done && idx_chg_tick >= 0 && n == idx_chg_tick) begin
        btn_up  = 1'b1;
        up_cnt  = 2;
        exp_idx = (exp_idx + 1) % N;
        chg_done = 1;
      end
      if (c > entry && !exp_busy) post++;
      if (post >= 4) break;
    end
    checks++;
    if (post < 4) begin
      errors++;
      $display("FAIL %s_timeout: ring did not complete within cycle budget", name);
    end
    check_idx({name, "_idx"});
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_ring();
    set_index(2);
    ring = 1'b1;
    repeat (2) step();
    ring = 1'b0;
    repeat (20) step();
    #2;
    rst_l = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0 || busy !== 1'b0 || tone_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_ring: out=%b busy=%b idx=%0d expected 0/0/0", out, busy, tone_idx);
    end
    exp_idx = 0;
    step();
    rst_l = 1'b1;
    repeat (2) step();
  endtask

`ifdef BELL_TONE_SEL_DEBOUNCE_EN
  task automatic test_debounce();
    btn_up = 1'b1;
    repeat (3 * P) step();
    btn_up = 1'b0;
    repeat (GAP) step();
    check_idx("deb_glitch");
    btn_up = 1'b1;
    repeat (12 * P) step();
    btn_up = 1'b0;
    repeat (GAP) step();
    exp_idx = (exp_idx + 1) % N;
    check_idx("deb_press");
  endtask
`endif

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_tone_index();
`ifdef BELL_TONE_SEL_DEBOUNCE_EN
    test_debounce();
`else
    test_ring("ring_tone0", 0, -1, -1);
    test_ring("ring_idx_change", 1, 5, -1);
    test_ring("ring_retrigger", 0, -1, 10);
    test_ring("ring_retrig_late", 1, -1, D - 1);
    for (int i = 0; i < 3; i++) begin
      test_ring("ring_random", $urandom_range(0, N - 1), -1,
                ($urandom_range(0, 1) == 1) ? $urandom_range(2, D - 2) : -1);
    end
    test_reset_mid_ring();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
